nibble_serial_adder: RTL



---
 rtl/nibble_serial_adder.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/nibble_serial_adder.sv
// Nibble-serial adder: one 4-bit carry-lookahead slice adds one digit per cycle.
// The carry is registered between digits and the result is published at the last digit.

module cla4 (
  output logic [3:0] sum,
  output logic       carry,
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic       cin
);

  logic [3:0] g;
  logic [3:0] p;
  logic [4:0] c;

  assign g = A & B;
  assign p = A ^ B;

  assign c[0] = cin;
  assign c[1] = g[0] | (p[0] & cin);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
  assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & cin);

  assign sum   = p ^ c[3:0];
  assign carry = c[4];

endmodule

module nibble_serial_adder #(
  parameter int NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [4*NIBBLES-1:0] A,
  input  logic [4*NIBBLES-1:0] B,
  input  logic                 cin,
  output logic                 busy,
  output logic                 done,
  output logic [4*NIBBLES-1:0] sum,
  output logic                 carry
);

  localparam int W  = 4 * NIBBLES;
  localparam int IW = $clog2(NIBBLES);
  localparam logic [IW-1:0] LAST_IDX = IW'(NIBBLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state;
  state_t          next_state;
  logic [W-1:0]    opa;
  logic [W-1:0]    opb;
  logic [W-1:0]    work;
  logic [W-1:0]    work_next;
  logic            cy;
  logic [IW-1:0]   idx;
  logic [3:0]      nib_a;
  logic [3:0]      nib_b;
  logic [3:0]      nib_sum;
  logic            nib_carry;
  logic            last;
  logic            capture;

  cla4 u_cla (
    .sum   (nib_sum),
    .carry (nib_carry),
    .A     (nib_a),
    .B     (nib_b),
    .cin   (cy)
  );

  // Operand digit select and working-result merge for the current index
  always_comb begin
    nib_a     = opa[{idx, 2'b00} +: 4];
    nib_b     = opb[{idx, 2'b00} +: 4];
    work_next = work;
    work_next[{idx, 2'b00} +: 4] = nib_sum;
    last      = (idx == LAST_IDX);
  end

  // Next-state logic; start is only honoured outside RUN
  always_comb begin
    next_state = state;
    capture    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          next_state = RUN;
          capture    = 1'b1;
        end else begin
          next_state = IDLE;
        end
      end
      RUN: begin
        if (last) begin
          next_state = DONE;
        end else begin
          next_state = RUN;
        end
      end
      DONE: begin
        if (start) begin
          next_state = RUN;
          capture    = 1'b1;
        end else begin
          next_state = IDLE;
        end
      end
      default: begin
        next_state = IDLE;
        capture    = 1'b0;
      end
    endcase
  end

  // State, datapath and registered status/result outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      opa   <= {W{1'b0}};
      opb   <= {W{1'b0}};
      work  <= {W{1'b0}};
      cy    <= 1'b0;
      idx   <= {IW{1'b0}};
      sum   <= {W{1'b0}};
      carry <= 1'b0;
    end else begin
      state <= next_state;
      busy  <= (next_state == RUN);
      done  <= (next_state == DONE);
      if (capture) begin
        opa <= A;
        opb <= B;
        cy  <= cin;
        idx <= {IW{1'b0}};
      end else if (state == RUN) begin
        work <= work_next;
        cy   <= nib_carry;
        if (last) begin
          idx   <= {IW{1'b0}};
          sum   <= work_next;
          carry <= nib_carry;
        end else begin
          idx <= idx + 1'b1;
        end
      end
    end
  end

endmodule
